imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the fetch stage reads.
- Accepts a byte stream on a valid/ready handshake and assembles big-endian 32-bit MIPS words.
- Writes each word into consecutive instruction-memory word addresses.
- Holds the PC (pc_write low) until the image is fully written, then releases fetch.

Parameters:
- PC_WIDTH, 6, byte-address width of the PC; informational, word address = PC[CODE_DIR_WIDTH+1:2].
- CODE_DIR_WIDTH, 4, instruction-memory word-address width.
- CODE_DEPTH, 16, number of words in instruction memory.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load; accepted only in IDLE or DONE.
- word_count  in  CODE_DIR_WIDTH+1  words to load; sampled on accepted start.
- byte_valid  in  1  source has a byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  CODE_DIR_WIDTH  word address.
- mem_wdata  out  32  word to write.
- pc_write  out  1  drives fetch-stage PCWrite; 0 = PC frozen.
- busy  out  1  load in progress.
- done  out  1  image loaded, core released.
- err  out  1  checksum mismatch (CHECKSUM_EN only; tied 0 otherwise).

Behaviour:
- Reset (rst=0 at clk edge): state IDLE.
  - All outputs 0; pc_write=0.
  - Word index, byte counter and shift register cleared.
- States: IDLE, RECV, WRITE, CHECK (macro only), DONE.
- Load length: word_count=0 or word_count>CODE_DEPTH → load CODE_DEPTH words; else load word_count words.
- IDLE/DONE + start=1 → RECV.
  - Index=0, byte cnt=0.
  - done=0, pc_write=0, err=0, busy=1 from next cycle.
- start while busy: ignored.
- RECV: byte_ready=1.
  - A transfer occurs when byte_valid & byte_ready at an edge.
  - Shift register: word = {word[23:0], byte_data}, so the first byte lands in bits [31:24].
  - On the 4th transfer → WRITE.
- WRITE: exactly one cycle.
  - byte_ready=0, mem_we=1, mem_addr=index, mem_wdata=assembled word.
  - If index==len-1 → CHECK (macro) or DONE; else index+1, byte cnt=0 → RECV.
- Latency: mem_we is asserted the cycle after the 4th byte's handshake edge.
- Maximum throughput: 5 cycles/word.
- DONE: busy=0, done=1, pc_write=1, mem_we=0, byte_ready=0. Held until a new start or reset.
- mem_addr/mem_wdata hold their last values outside WRITE; only mem_we qualifies them.
- byte_valid gaps: RECV waits indefinitely with no timeout; partial bytes are retained.
- Reset mid-load:
  - Immediate return to IDLE with pc_write=0.
  - Words already written remain in memory; no partial word is written.
- Index never wraps: the last index is CODE_DEPTH-1, after which the state leaves WRITE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - After the last WRITE, enter CHECK with byte_ready=1 and accept one extra byte.
  - The expected value is the XOR of all image bytes.
  - Mismatch → err=1.
  - Either way → DONE, but pc_write=1 only if err=0; with err=1, done=1 and pc_write stays 0.
- Disabled: no CHECK state, err tied 0, last WRITE → DONE directly.

Test Plan:
- Reset: rst=0 for 2 cycles → every output 0, byte_ready=0, pc_write=0.
- Basic load: start, word_count=2, bytes 8C,01,00,04,10,22,FF,FE with continuous valid:
  - mem_we pulses at addr 0 with 8C010004, then at addr 1 with 1022FFFE.
  - done=1, pc_write=1 on the cycle after the second write.
- Backpressure/gaps:
  - Same image with byte_valid low 3 cycles between bytes 2 and 3 → identical writes, no extra strobes.
  - byte_ready=0 during each WRITE cycle.
- Boundary:
  - word_count=0 → 16 writes, addr 0..15, with no write to a wrapped address.
  - word_count=31 → also 16 writes.
- Reset mid-load:
  - rst=0 after 6 bytes → 1 write only (addr 0), IDLE, pc_write=0.
  - A new start then loads from addr 0 again.
- Checksum (macro on): bytes 01,02,03,04 + checksum 04 → err=0, pc_write=1; checksum 05 → err=1, done=1, pc_write=0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words and writes them to instruction memory, holding the PC frozen until the whole image is written.
// Latency: mem_we is asserted the cycle after the 4th byte handshake of each word; a word takes at least 5 cycles.
// Backpressure: byte_ready is high only while collecting bytes (RECV, plus CHECK); it drops for the WRITE cycle. Optional checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int PC_WIDTH       = 6,
    parameter int CODE_DIR_WIDTH = 4,
    parameter int CODE_DEPTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CODE_DIR_WIDTH:0]   word_count,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    output logic                      byte_ready,
    output logic                      mem_we,
    output logic [CODE_DIR_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    output logic                      pc_write,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    // The PC addresses bytes; the word address is PC[CODE_DIR_WIDTH+1:2], so the PC must be wide enough.
    if (PC_WIDTH < CODE_DIR_WIDTH + 2) begin : g_pc_width_check
        $error("imem_loader: PC_WIDTH too small for CODE_DIR_WIDTH");
    end

    localparam logic [CODE_DIR_WIDTH:0]   DEPTH_W  = (CODE_DIR_WIDTH + 1)'(CODE_DEPTH);
    localparam logic [CODE_DIR_WIDTH-1:0] LAST_MAX = CODE_DIR_WIDTH'(CODE_DEPTH - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

    state_t                    state, state_nxt;
    logic [CODE_DIR_WIDTH-1:0] idx;
    logic [CODE_DIR_WIDTH-1:0] last_idx;
    logic [1:0]                byte_cnt;
    logic [23:0]               shift;
    logic                      start_acc;
    logic                      err_q;

    // State register; reset parks the loader in IDLE with the core frozen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        pc_write   = 1'b0;
        start_acc  = 1'b0;
        case (state)
            S_IDLE: begin
                start_acc = start;
                if (start) state_nxt = S_RECV;
            end
            S_RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && byte_cnt == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                if (idx == last_idx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = S_CHECK;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                done      = 1'b1;
                pc_write  = !err_q;
                start_acc = start;
                if (start) state_nxt = S_RECV;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of image bytes, compared against the trailing checksum byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            csum  <= 8'h00;
            err_q <= 1'b0;
        end else if (start_acc) begin
            csum  <= 8'h00;
            err_q <= 1'b0;
        end else if (state == S_RECV && byte_valid) begin
            csum <= csum ^ byte_data;
        end else if (state == S_CHECK && byte_valid) begin
            err_q <= (byte_data != csum);
        end
    end
`else
    assign err_q = 1'b0;
`endif

    assign err = err_q;

    // Word assembly, word index and the write-port registers (which hold between writes).
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx       <= '0;
            last_idx  <= '0;
            byte_cnt  <= 2'd0;
            shift     <= 24'h0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
        end else begin
            if (start_acc) begin
                idx      <= '0;
                byte_cnt <= 2'd0;
                // Zero or oversize counts mean "fill the whole memory".
                if (word_count == '0 || word_count > DEPTH_W) begin
                    last_idx <= LAST_MAX;
                end else begin
                    last_idx <= word_count[CODE_DIR_WIDTH-1:0] - 1'b1;
                end
            end
            if (state == S_RECV && byte_valid) begin
                shift    <= {shift[15:0], byte_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    mem_addr  <= idx;
                    mem_wdata <= {shift, byte_data};
                end
            end
            // Index stops at the last word so it can never wrap to address 0.
            if (state == S_WRITE && idx != last_idx) begin
                idx      <= idx + 1'b1;
                byte_cnt <= 2'd0;
            end
        end
    end

endmodule
